// File: rtl/taglist_player_if.sv
// +----------------------------------------------------------------------------+
// | taglist_player_if: request, tag RAM and ROM stream signals of the player   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface taglist_player_if #(
  parameter int TAG_ADDR_W = 7
);
  logic                  play_req;
  logic [6:0]            play_seq;
  logic [TAG_ADDR_W-1:0] tag_addr;
  logic [31:0]           tag_data;
  logic [9:0]            rom_addr;
  logic                  rom_valid;
  logic                  busy;
  logic                  done;
  logic                  not_found;

  modport master (
    output play_req, play_seq, tag_data,
    input  tag_addr, rom_addr, rom_valid, busy, done, not_found
  );

  modport slave (
    input  play_req, play_seq, tag_data,
    output tag_addr, rom_addr, rom_valid, busy, done, not_found
  );
endinterface

`default_nettype wire

// File: rtl/taglist_player.sv
// +----------------------------------------------------------------------------+
// | taglist_player: searches the tag RAM for a sequence, streams its ROM range |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module taglist_player #(
  parameter int TAG_ADDR_W = 7,
  parameter int RATE_DIV   = 1
) (
  input  wire logic         clk_50MHz,
  input  wire logic         reset,
  taglist_player_if.slave   tl_io
);

  localparam logic [2:0]  c_IDLE      = 3'd0;
  localparam logic [2:0]  c_LK_ADDR   = 3'd1;
  localparam logic [2:0]  c_LK_CHECK  = 3'd2;
  localparam logic [2:0]  c_PLAY      = 3'd3;
  localparam logic [2:0]  c_FINISH    = 3'd4;
  localparam logic [15:0] c_RATE_LAST = 16'(RATE_DIV - 1);

  logic [2:0]            state_q, state_d;
  logic [6:0]            seq_q, seq_d;
  logic [TAG_ADDR_W-1:0] idx_q, idx_d;
  logic [9:0]            cur_q, cur_d;
  logic [9:0]            end_q, end_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  nf_q, nf_d;

  logic [6:0] w_tag_seq;
  logic [9:0] w_tag_start;
  logic [9:0] w_tag_end;
  logic       w_tag_eof;
  logic [3:0] w_unused_hi;
  logic       w_strobe;

  assign w_tag_seq   = tl_io.tag_data[27:21];
  assign w_tag_start = tl_io.tag_data[20:11];
  assign w_tag_end   = tl_io.tag_data[10:1];
  assign w_tag_eof   = tl_io.tag_data[0];
  assign w_unused_hi = tl_io.tag_data[31:28];
  assign w_strobe    = (state_q == c_PLAY) && (cnt_q == 16'd0);

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= c_IDLE;
      seq_q   <= 7'd0;
      idx_q   <= '0;
      cur_q   <= 10'd0;
      end_q   <= 10'd0;
      cnt_q   <= 16'd0;
      nf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      nf_q    <= nf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    nf_d    = nf_q;
    case (state_q)
      c_IDLE: begin
        if (tl_io.play_req) begin
          seq_d = tl_io.play_seq;
          idx_d = '0;
          // A zero request skips the search and is rejected one cycle later in LK_CHECK
          state_d = (tl_io.play_seq != 7'd0) ? c_LK_ADDR : c_LK_CHECK;
        end
      end
      c_LK_ADDR: state_d = c_LK_CHECK;
      c_LK_CHECK: begin
        if (seq_q == 7'd0) begin
          nf_d    = 1'b1;
          state_d = c_FINISH;
        end else if (w_tag_seq == seq_q) begin
          if (w_tag_end >= w_tag_start) begin
            cur_d   = w_tag_start;
            end_d   = w_tag_end;
            cnt_d   = 16'd0;
            state_d = c_PLAY;
          end else begin
            nf_d    = 1'b1;
            state_d = c_FINISH;
          end
        end else if (w_tag_eof || (&idx_q)) begin
          nf_d    = 1'b1;
          state_d = c_FINISH;
        end else begin
          idx_d   = idx_q + TAG_ADDR_W'(1);
          state_d = c_LK_ADDR;
        end
      end
      c_PLAY: begin
        cnt_d = (cnt_q == c_RATE_LAST) ? 16'd0 : cnt_q + 16'd1;
        if (w_strobe) begin
          if (cur_q == end_q) begin
            nf_d    = 1'b0;
            state_d = c_FINISH;
          end else begin
            cur_d = cur_q + 10'd1;
          end
        end
      end
      c_FINISH: state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  always_comb begin
    tl_io.tag_addr  = idx_q;
    tl_io.rom_addr  = cur_q;
    tl_io.rom_valid = w_strobe;
    tl_io.busy      = (state_q == c_LK_ADDR) || (state_q == c_LK_CHECK) || (state_q == c_PLAY);
    tl_io.done      = (state_q == c_FINISH) && !nf_q;
    tl_io.not_found = (state_q == c_FINISH) && nf_q;
  end

endmodule

`default_nettype wire
